// File: rtl/rv32i_types.sv
// Shared RV32I types: machine word, RVFI monitor packet, commit-queue default depth.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef struct packed {
        logic [63:0] order;
        rv32i_word   insn;
        logic        trap;
        logic        halt;
        logic        intr;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        rv32i_word   rs1_rdata;
        rv32i_word   rs2_rdata;
        logic [4:0]  rd_addr;
        rv32i_word   rd_wdata;
        rv32i_word   pc_rdata;
        rv32i_word   pc_wdata;
    } RVFIMonPacket;

    localparam int RVFI_Q_DEPTH = 4;

endpackage

// File: rtl/rvfi_commit_slot.sv
// One commit-queue entry: packet storage plus valid/pending flags.
// clear drops the flags only; packet storage is cleared solely by rst.
module rvfi_commit_slot
    import rv32i_types::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         set,
    input  RVFIMonPacket set_pkt,
    input  logic         set_pending,
    input  logic         patch,
    input  rv32i_word    patch_data,
    input  logic         clear,
    output RVFIMonPacket pkt,
    output logic         valid,
    output logic         pending
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt     <= '0;
            valid   <= 1'b0;
            pending <= 1'b0;
        end else if (clear) begin
            valid   <= 1'b0;
            pending <= 1'b0;
        end else if (set) begin
            pkt     <= set_pkt;
            valid   <= 1'b1;
            pending <= set_pending;
        end else if (patch) begin
            pkt.rd_wdata <= patch_data;
            pending      <= 1'b0;
        end
    end

endmodule

// File: rtl/rvfi_commit_fifo.sv
// In-order RVFI packet queue between retire and monitor; entries may await a late
// rd_wdata writeback, patched by tag, with a same-cycle bypass onto the head.
module rvfi_commit_fifo
    import rv32i_types::*;
#(
    parameter  int DEPTH = RVFI_Q_DEPTH,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  RVFIMonPacket     in_pkt,
    input  logic             in_wait_wb,
    output logic [TAG_W-1:0] in_tag,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  rv32i_word        wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output RVFIMonPacket     out_pkt,
    output logic [TAG_W:0]   count
);

    logic [TAG_W-1:0] rd_ptr;
    logic [TAG_W-1:0] wr_ptr;
    RVFIMonPacket     slot_pkt [DEPTH];
    logic [DEPTH-1:0] slot_valid;
    logic [DEPTH-1:0] slot_pending;
    logic             enq;
    logic             deq;
    logic             bypass;

    assign in_ready = (count != (TAG_W+1)'(DEPTH));
    assign in_tag   = wr_ptr;

    // Head can commit the same cycle its writeback arrives.
    assign bypass    = slot_pending[rd_ptr] && wb_valid && (wb_tag == rd_ptr);
    assign out_valid = slot_valid[rd_ptr] && (!slot_pending[rd_ptr] || bypass);

    // flush blocks enqueue/dequeue/patch but does not mask out_valid.
    assign enq = in_valid && in_ready && !flush;
    assign deq = out_valid && out_ready && !flush;

    always_comb begin
        out_pkt = slot_pkt[rd_ptr];
        if (bypass) begin
            out_pkt.rd_wdata = wb_data;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic set_i;
        logic patch_i;
        logic clear_i;

        assign set_i   = enq && (wr_ptr == TAG_W'(i));
        assign patch_i = wb_valid && !flush && (wb_tag == TAG_W'(i))
                         && slot_valid[i] && slot_pending[i];
        // A bypassed head consumes its writeback: clear wins over patch.
        assign clear_i = flush || (deq && (rd_ptr == TAG_W'(i)));

        rvfi_commit_slot u_slot (
            .clk         (clk),
            .rst         (rst),
            .set         (set_i),
            .set_pkt     (in_pkt),
            .set_pending (in_wait_wb),
            .patch       (patch_i),
            .patch_data  (wb_data),
            .clear       (clear_i),
            .pkt         (slot_pkt[i]),
            .valid       (slot_valid[i]),
            .pending     (slot_pending[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + TAG_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + TAG_W'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + (TAG_W+1)'(1);
                2'b01:   count <= count - (TAG_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_rvfi_commit_fifo.sv
// Directed table-driven bench for rvfi_commit_fifo plus reset sequences.
module tb_rvfi_commit_fifo;
    import rv32i_types::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    RVFIMonPacket in_pkt;
    logic         in_wait_wb;
    logic [1:0]   in_tag;
    logic         wb_valid;
    logic [1:0]   wb_tag;
    rv32i_word    wb_data;
    logic         out_valid;
    logic         out_ready;
    RVFIMonPacket out_pkt;
    logic [2:0]   count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rvfi_commit_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pkt     (in_pkt),
        .in_wait_wb (in_wait_wb),
        .in_tag     (in_tag),
        .wb_valid   (wb_valid),
        .wb_tag     (wb_tag),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pkt    (out_pkt),
        .count      (count)
    );

    typedef struct {
        logic        iv;
        logic        ww;
        int          ord;
        logic        wv;
        logic [1:0]  wt;
        logic [31:0] wd;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        int          e_ord;
        logic [31:0] e_rd;
        int          e_cnt;
        logic        e_ir;
        int          e_tag;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] dr(input int o);
        return 32'h0000_F000 + o;
    endfunction

    function automatic RVFIMonPacket make_pkt(input int o);
        RVFIMonPacket p;
        p           = '0;
        p.order     = 64'(o);
        p.insn      = 32'h0000_0013 + o;
        p.rs1_addr  = 5'(o + 1);
        p.rs2_addr  = 5'(o + 2);
        p.rs1_rdata = 32'h1000_0000 + o;
        p.rs2_rdata = 32'h2000_0000 + o;
        p.rd_addr   = 5'(o);
        p.rd_wdata  = dr(o);
        p.pc_rdata  = 32'h8000_0000 + 4 * o;
        p.pc_wdata  = 32'h8000_0004 + 4 * o;
        return p;
    endfunction

    task automatic add(input logic iv, input logic ww, input int ord, input logic wv,
                       input logic [1:0] wt, input logic [31:0] wd, input logic ordy,
                       input logic fl, input logic e_ov, input int e_ord,
                       input logic [31:0] e_rd, input int e_cnt, input logic e_ir,
                       input int e_tag);
        vec_t v;
        v.iv = iv; v.ww = ww; v.ord = ord; v.wv = wv; v.wt = wt; v.wd = wd;
        v.ordy = ordy; v.fl = fl; v.e_ov = e_ov; v.e_ord = e_ord; v.e_rd = e_rd;
        v.e_cnt = e_cnt; v.e_ir = e_ir; v.e_tag = e_tag;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic ww, input int ord, input logic wv,
                         input logic [1:0] wt, input logic [31:0] wd, input logic ordy,
                         input logic fl);
        in_valid   = iv;
        in_wait_wb = ww;
        in_pkt     = make_pkt(ord);
        wb_valid   = wv;
        wb_tag     = wt;
        wb_data    = wd;
        out_ready  = ordy;
        flush      = fl;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_tag"}, 64'(in_tag), 64'd0);
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_out_pkt_zero"}, 64'(out_pkt == '0), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RVFIMonPacket ep;

        //  iv ww ord wv wt wd           rdy fl | ov ord rd           cnt ir tag
        // single packet, no writeback
        add(1, 0,  1, 0, 0, 0,            0, 0,   0,  0, 0,            0, 1, 0);
        add(0, 0,  0, 0, 0, 0,            0, 0,   1,  1, dr(1),        1, 1, 1);
        add(0, 0,  0, 0, 0, 0,            1, 0,   1,  1, dr(1),        1, 1, 1);
        add(0, 0,  0, 0, 0, 0,            0, 0,   0,  0, 0,            0, 1, 1);
        // pending head, same-cycle bypass
        add(1, 1,  1, 0, 0, 0,            0, 0,   0,  0, 0,            0, 1, 1);
        add(1, 0,  2, 0, 0, 0,            1, 0,   0,  0, 0,            1, 1, 2);
        add(0, 0,  0, 0, 0, 0,            1, 0,   0,  0, 0,            2, 1, 3);
        add(0, 0,  0, 1, 1, 32'hDEADBEEF, 1, 0,   1,  1, 32'hDEADBEEF, 2, 1, 3);
        add(0, 0,  0, 0, 0, 0,            1, 0,   1,  2, dr(2),        1, 1, 3);
        add(0, 0,  0, 0, 0, 0,            0, 0,   0,  0, 0,            0, 1, 3);
        // out-of-order patching
        add(1, 1,  1, 0, 0, 0,            0, 0,   0,  0, 0,            0, 1, 3);
        add(1, 1,  2, 0, 0, 0,            0, 0,   0,  0, 0,            1, 1, 0);
        add(0, 0,  0, 1, 0, 32'h11,       0, 0,   0,  0, 0,            2, 1, 1);
        add(0, 0,  0, 1, 3, 32'h22,       0, 0,   1,  1, 32'h22,       2, 1, 1);
        add(0, 0,  0, 0, 0, 0,            1, 0,   1,  1, 32'h22,       2, 1, 1);
        add(0, 0,  0, 0, 0, 0,            1, 0,   1,  2, 32'h11,       1, 1, 1);
        add(0, 0,  0, 0, 0, 0,            0, 0,   0,  0, 0,            0, 1, 1);
        // fill, full with dequeue, then wrap
        add(1, 0, 10, 0, 0, 0,            0, 0,   0,  0, 0,            0, 1, 1);
        add(1, 0, 11, 0, 0, 0,            0, 0,   1, 10, dr(10),       1, 1, 2);
        add(1, 0, 12, 0, 0, 0,            0, 0,   1, 10, dr(10),       2, 1, 3);
        add(1, 0, 13, 0, 0, 0,            0, 0,   1, 10, dr(10),       3, 1, 0);
        add(1, 0, 99, 0, 0, 0,            1, 0,   1, 10, dr(10),       4, 0, 1);
        add(0, 0,  0, 0, 0, 0,            0, 0,   1, 11, dr(11),       3, 1, 1);
        add(1, 0, 14, 0, 0, 0,            1, 0,   1, 11, dr(11),       3, 1, 1);
        add(1, 0, 15, 0, 0, 0,            1, 0,   1, 12, dr(12),       3, 1, 2);
        add(1, 0, 16, 0, 0, 0,            1, 0,   1, 13, dr(13),       3, 1, 3);
        add(1, 0, 17, 0, 0, 0,            1, 0,   1, 14, dr(14),       3, 1, 0);
        add(1, 0, 18, 0, 0, 0,            1, 0,   1, 15, dr(15),       3, 1, 1);
        add(1, 0, 19, 0, 0, 0,            1, 0,   1, 16, dr(16),       3, 1, 2);
        add(0, 0,  0, 0, 0, 0,            1, 0,   1, 17, dr(17),       3, 1, 3);
        add(0, 0,  0, 0, 0, 0,            1, 0,   1, 18, dr(18),       2, 1, 3);
        add(0, 0,  0, 0, 0, 0,            1, 0,   1, 19, dr(19),       1, 1, 3);
        add(0, 0,  0, 0, 0, 0,            0, 0,   0,  0, 0,            0, 1, 3);
        // flush with simultaneous writeback, then stale tag
        add(1, 1, 20, 0, 0, 0,            0, 0,   0,  0, 0,            0, 1, 3);
        add(1, 1, 21, 0, 0, 0,            0, 0,   0,  0, 0,            1, 1, 0);
        add(1, 1, 22, 0, 0, 0,            0, 0,   0,  0, 0,            2, 1, 1);
        add(1, 0, 23, 1, 3, 32'h33,       1, 1,   1, 20, 32'h33,       3, 1, 2);
        add(0, 0,  0, 0, 0, 0,            0, 0,   0,  0, 0,            0, 1, 0);
        add(0, 0,  0, 1, 1, 32'h44,       0, 0,   0,  0, 0,            0, 1, 0);
        // writeback to non-pending and to empty slots
        add(1, 0, 30, 0, 0, 0,            0, 0,   0,  0, 0,            0, 1, 0);
        add(0, 0,  0, 1, 0, 32'h55,       0, 0,   1, 30, dr(30),       1, 1, 1);
        add(0, 0,  0, 0, 0, 0,            1, 0,   1, 30, dr(30),       1, 1, 1);
        add(0, 0,  0, 1, 1, 32'h66,       0, 0,   0,  0, 0,            0, 1, 1);
        add(1, 1, 31, 0, 0, 0,            0, 0,   0,  0, 0,            0, 1, 1);
        add(0, 0,  0, 0, 0, 0,            0, 0,   0,  0, 0,            1, 1, 2);
        add(0, 0,  0, 1, 1, 32'h77,       1, 0,   1, 31, 32'h77,       1, 1, 2);
        add(0, 0,  0, 0, 0, 0,            0, 0,   0,  0, 0,            0, 1, 2);

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_state("reset");

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].iv, vecs[i].ww, vecs[i].ord, vecs[i].wv, vecs[i].wt,
                  vecs[i].wd, vecs[i].ordy, vecs[i].fl);
            #1;
            chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            chk($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].e_cnt));
            chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_ir));
            chk($sformatf("v%0d_in_tag", i), 64'(in_tag), 64'(vecs[i].e_tag));
            if (vecs[i].e_ov) begin
                ep          = make_pkt(vecs[i].e_ord);
                ep.rd_wdata = vecs[i].e_rd;
                chk($sformatf("v%0d_order", i), out_pkt.order, 64'(vecs[i].e_ord));
                chk($sformatf("v%0d_rd_wdata", i), 64'(out_pkt.rd_wdata), 64'(vecs[i].e_rd));
                chk($sformatf("v%0d_pkt_eq", i), 64'(out_pkt == ep), 64'd1);
            end
        end

        // Reset mid-operation: entries lost, storage cleared, stale writeback ignored.
        @(negedge clk); drive(1, 0, 40, 0, 0, 0, 0, 0);
        @(negedge clk); drive(1, 1, 41, 0, 0, 0, 0, 0);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("midrst_pre_count", 64'(count), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_state("midrst");
        @(negedge clk); drive(0, 0, 0, 1, 3, 32'h88, 1, 0);
        #1;
        chk("stale_wb_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk); drive(1, 0, 42, 0, 0, 0, 0, 0);
        #1;
        chk("stale_wb_count", 64'(count), 64'd0);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("post_rst_out_valid", 64'(out_valid), 64'd1);
        chk("post_rst_order", out_pkt.order, 64'd42);
        chk("post_rst_rd_wdata", 64'(out_pkt.rd_wdata), 64'(dr(42)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
